// File: rtl/music_voice_allocator.sv
// music_voice_allocator: assigns six active-low music keys to a pool of shared voices and runs each voice's envelope.
//   CLK_32Khz       sole clock
//   reset_n         asynchronous active-low reset
//   currentState    controller state; voices sound only in states 0 and 4
//   input_MusicKey  raw keys, 0 = pressed
//   voice_active    per voice, 1 = HELD or RELEASE
//   voice_keyIndex  packed 3-bit owning key per voice (0 while idle)
//   voice_amplitude packed 8-bit envelope amplitude per voice
//   steal_count     saturating count of voice steals
module music_voice_allocator #(
    parameter int NUM_VOICES    = 3,
    parameter int TICK_DIV      = 32,
    parameter int PEAK_LEVEL    = 255,
    parameter int SUSTAIN_LEVEL = 200,
    parameter int DECAY_STEP    = 3
) (
    input  logic                    CLK_32Khz,
    input  logic                    reset_n,
    input  logic [4:0]              currentState,
    input  logic [5:0]              input_MusicKey,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [3*NUM_VOICES-1:0] voice_keyIndex,
    output logic [8*NUM_VOICES-1:0] voice_amplitude,
    output logic [7:0]              steal_count
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] PEAK = 8'(PEAK_LEVEL);
    localparam logic [7:0] SUS  = 8'(SUSTAIN_LEVEL);
    localparam logic [7:0] DEC  = 8'(DECAY_STEP);

    typedef enum logic [1:0] {IDLE, HELD, REL} vstate_e;

    logic [5:0]    sync1_q, sync2_q, hist_q, pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    steal_q, steal_d;
    vstate_e       st_q  [NUM_VOICES];
    vstate_e       st_d  [NUM_VOICES];
    logic [2:0]    key_q [NUM_VOICES];
    logic [2:0]    key_d [NUM_VOICES];
    logic [7:0]    amp_q [NUM_VOICES];
    logic [7:0]    amp_d [NUM_VOICES];
    logic [7:0]    age_q [NUM_VOICES];
    logic [7:0]    age_d [NUM_VOICES];

    logic          gate, tick, svc_v, alloc, steal;
    logic          own_f, idle_f, rel_f, held_f;
    logic [5:0]    press_e, rel_e, cand, svc_oh;
    logic [2:0]    svc_k;
    logic [VW-1:0] own_i, idle_i, rel_i, held_i, win;
    logic [7:0]    rel_amp, held_age;

    function automatic logic [7:0] held_next(input logic [7:0] a);
        return (a <= SUS) ? a : (a - SUS > DEC) ? a - DEC : SUS;
    endfunction

    function automatic logic [7:0] rel_next(input logic [7:0] a);
        logic [7:0] d;
        d = (a > SUS) ? DEC + 8'd2 : (a > 8'd100) ? 8'd2 : 8'd1;
        return (a > d) ? a - d : 8'd0;
    endfunction

    // Edge detection, tick generation and pending-press service selection.
    always_comb begin
        gate    = (currentState != 5'd0) && (currentState != 5'd4);
        tick    = cnt_q == CW'(TICK_DIV - 1);
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        press_e = hist_q & ~sync2_q;
        rel_e   = ~hist_q & sync2_q;
        // A release arriving while the press is still pending cancels it.
        cand    = pend_q & ~rel_e;
        svc_oh  = cand & (~cand + 6'd1);
        svc_v   = |cand;
        svc_k   = 3'd0;
        for (int k = 5; k >= 0; k--)
            if (cand[k]) svc_k = 3'(k);
        pend_d  = gate ? 6'd0 : (pend_q & ~rel_e & ~svc_oh) | press_e;
    end

    // Voice choice for the serviced key: retrigger, idle, quietest release, oldest held.
    always_comb begin
        own_f    = 1'b0;
        idle_f   = 1'b0;
        rel_f    = 1'b0;
        held_f   = 1'b0;
        own_i    = '0;
        idle_i   = '0;
        rel_i    = '0;
        held_i   = '0;
        rel_amp  = 8'd0;
        held_age = 8'd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (st_q[v] != IDLE && key_q[v] == svc_k && !own_f) begin
                own_f = 1'b1;
                own_i = VW'(v);
            end
            if (st_q[v] == IDLE && !idle_f) begin
                idle_f = 1'b1;
                idle_i = VW'(v);
            end
            if (st_q[v] == REL && (!rel_f || amp_q[v] < rel_amp)) begin
                rel_f   = 1'b1;
                rel_i   = VW'(v);
                rel_amp = amp_q[v];
            end
            if (st_q[v] == HELD && (!held_f || age_q[v] > held_age)) begin
                held_f   = 1'b1;
                held_i   = VW'(v);
                held_age = age_q[v];
            end
        end
        win     = own_f ? own_i : idle_f ? idle_i : rel_f ? rel_i : held_i;
        alloc   = svc_v && !gate;
        steal   = alloc && !own_f && !idle_f;
        steal_d = (steal && steal_q != 8'hFF) ? steal_q + 8'd1 : steal_q;
    end

    // Per-voice envelope FSM; later assignments take priority (release over tick, allocation over both, gating over all).
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            st_d[v]  = st_q[v];
            key_d[v] = key_q[v];
            amp_d[v] = amp_q[v];
            age_d[v] = age_q[v];
            if (tick && st_q[v] != IDLE)
                age_d[v] = (age_q[v] == 8'hFF) ? age_q[v] : age_q[v] + 8'd1;
            if (tick && st_q[v] == HELD)
                amp_d[v] = held_next(amp_q[v]);
            if (tick && st_q[v] == REL) begin
                amp_d[v] = rel_next(amp_q[v]);
                st_d[v]  = (amp_d[v] == 8'd0) ? IDLE : REL;
            end
            if (st_q[v] == HELD && rel_e[key_q[v]])
                st_d[v] = REL;
            if (alloc && win == VW'(v)) begin
                st_d[v]  = HELD;
                key_d[v] = svc_k;
                amp_d[v] = PEAK;
                age_d[v] = 8'd0;
            end
            if (gate) begin
                st_d[v]  = IDLE;
                key_d[v] = 3'd0;
                amp_d[v] = 8'd0;
                age_d[v] = 8'd0;
            end
        end
    end

    // While gated the synchronizer stages are held high as well, so a key held
    // through gating goes through the full press latency when gating lifts.
    always_ff @(posedge CLK_32Khz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 6'h3F;
            sync2_q <= 6'h3F;
            hist_q  <= 6'h3F;
            pend_q  <= 6'd0;
            cnt_q   <= '0;
            steal_q <= 8'd0;
            st_q    <= '{default: IDLE};
            key_q   <= '{default: 3'd0};
            amp_q   <= '{default: 8'd0};
            age_q   <= '{default: 8'd0};
        end else begin
            sync1_q <= gate ? 6'h3F : input_MusicKey;
            sync2_q <= gate ? 6'h3F : sync1_q;
            hist_q  <= gate ? 6'h3F : sync2_q;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            steal_q <= steal_d;
            st_q    <= st_d;
            key_q   <= key_d;
            amp_q   <= amp_d;
            age_q   <= age_d;
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_out
        assign voice_active[i]           = st_q[i] != IDLE;
        assign voice_keyIndex[3*i +: 3]  = (st_q[i] != IDLE) ? key_q[i] : 3'd0;
        assign voice_amplitude[8*i +: 8] = amp_q[i];
    end

    assign steal_count = steal_q;
endmodule

// File: tb/tb_music_voice_allocator.sv
// tb_music_voice_allocator: randomized scoreboard bench for music_voice_allocator against a behavioural model.
module tb_music_voice_allocator;
    localparam int NV   = 3;
    localparam int TD   = 32;
    localparam int PEAK = 255;
    localparam int SUS  = 200;
    localparam int DEC  = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [4:0]      cstate = 5'd0;
    logic [5:0]      keys = 6'h3F;
    logic [NV-1:0]   act;
    logic [3*NV-1:0] kix;
    logic [8*NV-1:0] amp;
    logic [7:0]      sc;
    int              checks = 0;
    int              errors = 0;

    music_voice_allocator #(
        .NUM_VOICES(NV), .TICK_DIV(TD), .PEAK_LEVEL(PEAK),
        .SUSTAIN_LEVEL(SUS), .DECAY_STEP(DEC)
    ) dut (
        .CLK_32Khz(clk), .reset_n(reset_n), .currentState(cstate),
        .input_MusicKey(keys), .voice_active(act), .voice_keyIndex(kix),
        .voice_amplitude(amp), .steal_count(sc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV-1:0]   act;
        logic [3*NV-1:0] key;
        logic [8*NV-1:0] amp;
        logic [7:0]      sc;
    } exp_t;
    exp_t q[$];

    // Model state: voice state 0 = idle, 1 = held, 2 = release.
    bit [5:0] m_s1, m_s2, m_h, m_pend;
    int m_st[NV], m_key[NV], m_amp[NV], m_age[NV];
    int m_steal, m_cnt;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 6'h3F; m_s2 = 6'h3F; m_h = 6'h3F; m_pend = 6'd0;
        m_steal = 0; m_cnt = 0;
        for (int v = 0; v < NV; v++) begin
            m_st[v] = 0; m_key[v] = 0; m_amp[v] = 0; m_age[v] = 0;
        end
    endtask

    task automatic model_step();
        int nst[NV], nkey[NV], namp[NV], nage[NV];
        bit gated, tick, stolen;
        bit [5:0] pr, rl;
        int svc, w, d;
        gated = !(cstate == 5'd0 || cstate == 5'd4);
        tick  = (m_cnt == TD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        pr = m_h & ~m_s2;
        rl = ~m_h & m_s2;
        svc = -1;
        for (int k = 5; k >= 0; k--) if (m_pend[k] && !rl[k]) svc = k;
        for (int v = 0; v < NV; v++) begin
            nst[v] = m_st[v]; nkey[v] = m_key[v]; namp[v] = m_amp[v]; nage[v] = m_age[v];
            if (tick && m_st[v] != 0) nage[v] = (m_age[v] + 1 > 255) ? 255 : m_age[v] + 1;
            if (tick && m_st[v] == 1 && m_amp[v] > SUS)
                namp[v] = (m_amp[v] - DEC < SUS) ? SUS : m_amp[v] - DEC;
            if (tick && m_st[v] == 2) begin
                d = (m_amp[v] > SUS) ? DEC + 2 : (m_amp[v] > 100) ? 2 : 1;
                namp[v] = (m_amp[v] - d < 0) ? 0 : m_amp[v] - d;
                if (namp[v] == 0) nst[v] = 0;
            end
            if (m_st[v] == 1 && rl[m_key[v]]) nst[v] = 2;
        end
        if (svc >= 0 && !gated) begin
            w = -1; stolen = 0;
            for (int v = 0; v < NV; v++) if (w < 0 && m_st[v] != 0 && m_key[v] == svc) w = v;
            for (int v = 0; v < NV; v++) if (w < 0 && m_st[v] == 0) w = v;
            if (w < 0) begin
                stolen = 1;
                for (int v = 0; v < NV; v++) if (m_st[v] == 2 && (w < 0 || m_amp[v] < m_amp[w])) w = v;
                if (w < 0)
                    for (int v = 0; v < NV; v++) if (m_st[v] == 1 && (w < 0 || m_age[v] > m_age[w])) w = v;
            end
            nst[w] = 1; nkey[w] = svc; namp[w] = PEAK; nage[w] = 0;
            if (stolen && m_steal < 255) m_steal++;
        end
        if (svc >= 0) m_pend[svc] = 1'b0;
        m_pend = (m_pend & ~rl) | pr;
        if (gated) begin
            m_pend = 6'd0; m_s1 = 6'h3F; m_s2 = 6'h3F; m_h = 6'h3F;
            for (int v = 0; v < NV; v++) begin
                nst[v] = 0; nkey[v] = 0; namp[v] = 0; nage[v] = 0;
            end
        end else begin
            m_h = m_s2; m_s2 = m_s1; m_s1 = keys;
        end
        m_st = nst; m_key = nkey; m_amp = namp; m_age = nage;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.act = '0; e.key = '0; e.amp = '0;
        for (int v = 0; v < NV; v++) begin
            e.act[v] = (m_st[v] != 0);
            if (m_st[v] != 0) e.key[3*v +: 3] = 3'(m_key[v]);
            e.amp[8*v +: 8] = 8'(m_amp[v]);
        end
        e.sc = 8'(m_steal);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else model_step();
        q.push_back(expect_now());
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
            else begin
                e = q.pop_front();
                chk("active", 32'(act), 32'(e.act));
                chk("keyIndex", 32'(kix), 32'(e.key));
                chk("amplitude", 32'(amp), 32'(e.amp));
                chk("steal_count", 32'(sc), 32'(e.sc));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        cyc(3);
        chk("reset_active", 32'(act), 32'd0);
        chk("reset_amp", 32'(amp), 32'd0);
        reset_n = 1'b1;
        cyc(2);
        keys = 6'b111011;
        cyc(4);
        chk("press_k2_active", 32'(act), 32'd1);
        chk("press_k2_key", 32'(kix[2:0]), 32'd2);
        chk("press_k2_peak", 32'(amp[7:0]), 32'd255);
        cyc(700);
        chk("sustain_200", 32'(amp[7:0]), 32'd200);
        keys = 6'h3F;
        cyc(3);
        chk("release_active", 32'(act), 32'd1);
        cyc(5000);
        chk("release_idle", 32'(act), 32'd0);
        chk("release_amp0", 32'(amp), 32'd0);
        keys = 6'b111000;
        cyc(6);
        chk("three_keys", 32'(kix), 32'b010_001_000);
        chk("three_active", 32'(act), 32'b111);
        chk("three_nosteal", 32'(sc), 32'd0);
        cyc(100);
        keys = 6'b011000;
        cyc(4);
        chk("steal_key", 32'(kix), 32'b010_001_101);
        chk("steal_peak", 32'(amp[7:0]), 32'd255);
        chk("steal_count1", 32'(sc), 32'd1);
        keys = 6'h3F;
        cyc(6000);
        chk("all_idle", 32'(act), 32'd0);
        keys = 6'b110111;
        cyc(700);
        keys = 6'h3F;
        cyc(800);
        keys = 6'b110111;
        cyc(4);
        chk("retrig_active", 32'(act), 32'b001);
        chk("retrig_key", 32'(kix), 32'd3);
        chk("retrig_peak", 32'(amp[7:0]), 32'd255);
        chk("retrig_nosteal", 32'(sc), 32'd1);
        keys = 6'b111101;
        cyc(10);
        cstate = 5'd2;
        cyc(1);
        chk("gate_active", 32'(act), 32'd0);
        chk("gate_key", 32'(kix), 32'd0);
        chk("gate_amp", 32'(amp), 32'd0);
        chk("gate_steal_hold", 32'(sc), 32'd1);
        cstate = 5'd0;
        cyc(3);
        chk("ungate_wait", 32'(act), 32'd0);
        cyc(1);
        chk("ungate_active", 32'(act), 32'b001);
        chk("ungate_key", 32'(kix), 32'd1);
        chk("ungate_peak", 32'(amp[7:0]), 32'd255);
        cyc(50);
        reset_n = 1'b0;
        #1;
        chk("async_rst_active", 32'(act), 32'd0);
        chk("async_rst_amp", 32'(amp), 32'd0);
        chk("async_rst_steal", 32'(sc), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            if ($urandom_range(0, 39) == 0) keys[$urandom_range(0, 5)] ^= 1'b1;
            if ($urandom_range(0, 1499) == 0) begin
                cstate = 5'($urandom_range(0, 7));
                if (cstate[0]) cstate = 5'd0;
            end
            if ($urandom_range(0, 9999) == 0) begin
                reset_n = 1'b0;
                cyc(2);
                reset_n = 1'b1;
            end
            cyc(1);
        end
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
